debounce_bank: RTL

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_pkg.sv | 15 +
 rtl/debounce_channel.sv | 90 +++++++++
 rtl/debounce_bank.sv | 51 +++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the debounce bank.
// Holds the per-channel FSM state encoding and the counter-width function.
package debounce_pkg;

   typedef enum logic {
      WAIT  = 1'b0,
      COUNT = 1'b1
   } state_t;

   // Wide enough to hold DELAY_CC itself, so the counter can never wrap.
   function automatic int cnt_width(input int delay_cc);
      return $clog2(delay_cc + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: input synchroniser, WAIT/COUNT stability FSM,
// debounced level register and registered rise/fall pulses.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int   DELAY_CC    = 50000,
   parameter int   SYNC_STAGES = 2,
   parameter logic FAST_ASSERT = 1'b0,
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall,
   output logic busy_next
);

   localparam int CNT_W = cnt_width(DELAY_CC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_CC - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   state_t                 state, state_n;
   logic [CNT_W-1:0]       cnt, cnt_n;
   logic                   level_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= {SYNC_STAGES{RESET_VALUE}};
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], raw};
      end
   end

   assign s = sync[SYNC_STAGES-1];

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      level_n = level;
      case (state)
         WAIT: begin
            cnt_n = '0;
            if (s != level) begin
               // Fast-assert lanes take a rising level immediately; falling still debounces.
               if (FAST_ASSERT && !level) begin
                  level_n = 1'b1;
               end else begin
                  state_n = COUNT;
                  cnt_n   = CNT_W'(1);
               end
            end
         end
         COUNT: begin
            if (s == level) begin
               state_n = WAIT;
               cnt_n   = '0;
            end else if (cnt == CNT_LAST) begin
               level_n = s;
               state_n = WAIT;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= WAIT;
         cnt   <= '0;
         level <= RESET_VALUE;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         level <= level_n;
         rise  <= level_n & ~level;
         fall  <= ~level_n & level;
      end
   end

   // Exposed pre-register so the top-level busy flop lines up with the COUNT state.
   assign busy_next = (state_n == COUNT);

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced inputs with per-channel fast-assert and
// reset-value options plus an aggregate busy flag.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int                  CHANNELS         = 4,
   parameter int                  DELAY_CC         = 50000,
   parameter int                  SYNC_STAGES      = 2,
   parameter logic [CHANNELS-1:0] FAST_ASSERT_MASK = '0,
   parameter logic [CHANNELS-1:0] RESET_VALUE      = '0
) (
   input  logic                piul1Clock,
   input  logic                piul1Reset,
   input  logic [CHANNELS-1:0] piulvIn,
   output logic [CHANNELS-1:0] poulvOut,
   output logic [CHANNELS-1:0] poulvRise,
   output logic [CHANNELS-1:0] poulvFall,
   output logic                poul1Busy
);

   logic [CHANNELS-1:0] busy_next;
   logic                busy;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      debounce_channel #(
         .DELAY_CC    (DELAY_CC),
         .SYNC_STAGES (SYNC_STAGES),
         .FAST_ASSERT (FAST_ASSERT_MASK[g]),
         .RESET_VALUE (RESET_VALUE[g])
      ) u_ch (
         .clk       (piul1Clock),
         .rst       (piul1Reset),
         .raw       (piulvIn[g]),
         .level     (poulvOut[g]),
         .rise      (poulvRise[g]),
         .fall      (poulvFall[g]),
         .busy_next (busy_next[g])
      );
   end

   always_ff @(posedge piul1Clock) begin
      if (piul1Reset) begin
         busy <= 1'b0;
      end else begin
         busy <= |busy_next;
      end
   end

   assign poul1Busy = busy;

endmodule
